// File: rtl/ex_hazard_control_if.sv
// Execute-stage hazard control bus: decode-side inputs and the select/stall outputs.
interface ex_hazard_control_if;
  logic [31:0] ir2_output;
  logic        branch_control_input;
  logic [1:0]  select_operand1;
  logic [1:0]  select_operand2;
  logic [1:0]  select_md4;
  logic        select_ir4;
  logic        stall;
  logic        bubble;
  logic        flush_active;

  // Pipeline side: supplies the decode instruction and branch outcome.
  modport master (
    output ir2_output,
    output branch_control_input,
    input  select_operand1,
    input  select_operand2,
    input  select_md4,
    input  select_ir4,
    input  stall,
    input  bubble,
    input  flush_active
  );

  // Controller side.
  modport slave (
    input  ir2_output,
    input  branch_control_input,
    output select_operand1,
    output select_operand2,
    output select_md4,
    output select_ir4,
    output stall,
    output bubble,
    output flush_active
  );
endinterface

// File: rtl/ex_hazard_control.sv
// Execute-stage hazard controller: operand forwarding selects, load-use stall,
// and a two-cycle squash after a taken branch. Keeps a two-deep scoreboard of
// destination registers mirroring ir3 (ex) and ir4 (mem).
module ex_hazard_control (
  input logic                clk,
  input logic                reset,
  ex_hazard_control_if.slave hz
);
  localparam logic [6:0] OpAlu    = 7'b0110011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StRun, StFlush1, StFlush2} state_e;

  state_e     state_q, state_d;
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_load_q, ex_load_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic [1:0] sel_op1_q, sel_op1_d;
  logic [1:0] sel_op2_q, sel_op2_d;
  logic [1:0] sel_md4_q, sel_md4_d;

  // Decode of the instruction waiting in ir2.
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       writes_rd, is_load, uses_rs1, uses_rs2;
  logic       load_use, take_branch;
  logic       unused_ir;

  assign opcode    = hz.ir2_output[6:0];
  assign rd        = hz.ir2_output[11:7];
  assign rs1       = hz.ir2_output[19:15];
  assign rs2       = hz.ir2_output[24:20];
  assign unused_ir = ^{hz.ir2_output[31:25], hz.ir2_output[14:12]};

  assign writes_rd = (opcode inside {OpAlu, OpAluImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr})
                     && (rd != 5'd0);
  assign is_load   = (opcode == OpLoad);
  assign uses_rs1  = !(opcode inside {OpLui, OpAuipc, OpJal});
  assign uses_rs2  = opcode inside {OpAlu, OpStore, OpBranch};

  // Younger producer (z4) wins over the older one (z5). Records never hold rd = x0.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic exv,
                                         input logic [4:0] exrd, input logic memv,
                                         input logic [4:0] memrd);
    if (exv && (src == exrd)) begin
      return 2'b10;
    end else if (memv && (src == memrd)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign take_branch = (state_q == StRun) && hz.branch_control_input;
  assign load_use    = (state_q == StRun) && ex_valid_q && ex_load_q &&
                       ((uses_rs1 && (rs1 == ex_rd_q)) || (uses_rs2 && (rs2 == ex_rd_q)));

  // Next-state: scoreboard shift, select computation and flush sequencing.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    ex_valid_d  = 1'b0;
    ex_rd_d     = '0;
    ex_load_d   = 1'b0;
    sel_op1_d   = 2'b00;
    sel_op2_d   = 2'b00;
    sel_md4_d   = 2'b00;
    unique case (state_q)
      StRun: begin
        if (take_branch) begin
          state_d = StFlush1;
        end else if (!load_use) begin
          ex_valid_d = writes_rd;
          ex_rd_d    = rd;
          ex_load_d  = is_load;
          if (uses_rs1) begin
            sel_op1_d = fwd_sel(rs1, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q);
          end
          if ((opcode == OpAlu) || (opcode == OpBranch)) begin
            sel_op2_d = fwd_sel(rs2, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q);
          end
          if (opcode == OpStore) begin
            sel_md4_d = fwd_sel(rs2, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q);
          end
        end
      end
      StFlush1: state_d = StFlush2;
      StFlush2: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // State, scoreboard and registered selects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      sel_op1_q   <= 2'b00;
      sel_op2_q   <= 2'b00;
      sel_md4_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      sel_op1_q   <= sel_op1_d;
      sel_op2_q   <= sel_op2_d;
      sel_md4_q   <= sel_md4_d;
    end
  end

  assign hz.select_operand1 = sel_op1_q;
  assign hz.select_operand2 = sel_op2_q;
  assign hz.select_md4      = sel_md4_q;
  assign hz.flush_active    = (state_q != StRun);
  assign hz.select_ir4      = (state_q != StRun);
  // A taken branch squashes the hazard, so no stall in that cycle.
  assign hz.stall           = load_use && !take_branch;
  assign hz.bubble          = load_use && !take_branch;
endmodule
